cost_port_arbiter: RTL and testbench
====================================

# cost_port_arbiter

Round-robin, burst-locking arbiter that shares the single Cost lookup port (W/J out, Cost in) between two permutation-evaluation engines. Each engine issues 3-bit worker/job lookups; the arbiter drives the shared W/J pair, captures the returned Cost, and routes it back to the issuing engine. A burst (for example, the 8 lookups of one permutation) keeps the port locked to one engine until its last beat. A watchdog frees the lock if the owner stalls.

## Interface
Parameters:
- LOCK_TIMEOUT, 16: consecutive owner-stall cycles (req low while locked) that force lock release; valid range 2..255.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- req  in  2  per-engine lookup request; bit i = engine i
- req_last  in  2  beat is the last of engine i's burst
- req_w  in  6  worker index; [2:0] engine 0, [5:3] engine 1
- req_j  in  6  job index; [2:0] engine 0, [5:3] engine 1
- gnt  out  2  combinational; beat of engine i accepted when req[i] & gnt[i]
- W  out  3  registered worker index to cost table
- J  out  3  registered job index to cost table
- Cost  in  7  cost table data; combinational function of W/J, valid during the cycle after W/J update
- rsp_valid  out  2  one-cycle pulse; response for engine i
- rsp_cost  out  7  returned Cost
- rsp_last  out  1  response belongs to a last beat
- busy  out  1  port locked to an owner (state OWNED)
- err_timeout  out  1  one-cycle pulse when the watchdog releases a lock

## Operation
- Reset is asynchronous, active-high on RST, clock CLK. Reset values: W=0, J=0, rsp_valid=0, rsp_cost=0, rsp_last=0, busy=0, err_timeout=0. Internal state: state=IDLE, rr=0, idle_cnt=0, pipeline valid=0. gnt=0 while req=0.
- States:
  - IDLE: no owner. Winner = the only requester if one requests, else engine rr if both request; gnt[winner]=1, other 0. On an accepted beat:
    - req_last=1 → stay IDLE, rr <= ~winner.
    - req_last=0 → OWNED, owner <= winner, idle_cnt <= 0.
  - OWNED: gnt[owner]=req[owner], gnt[~owner]=0 regardless of other request.
    - Accepted beat with req_last=1 → IDLE, rr <= ~owner.
    - Accepted beat with req_last=0 → stay, idle_cnt <= 0.
    - req[owner]=0 and idle_cnt==LOCK_TIMEOUT-1 → IDLE, rr <= ~owner, err_timeout pulses next cycle.
    - req[owner]=0 otherwise → idle_cnt+1.
- Accepted beat: W/J <= winner's req_w/req_j slice; stage-1 tag/last/valid registered.
- Stage 2: when stage-1 valid, rsp_cost <= Cost, rsp_last <= stage-1 last, rsp_valid[tag] <= 1. Otherwise rsp_valid <= 0; rsp_cost and rsp_last hold.
- W/J hold their last value when no beat is accepted.
- Costs are 7-bit, passed through unmodified; no arithmetic in this block.
- busy = (state==OWNED).

## Timing
- Throughput is one beat per cycle, including back-to-back beats from the same engine and alternating engines across single-beat bursts.
- Latency: beat accepted at edge t → W/J valid after t → rsp_valid high in the cycle after edge t+1, i.e. 2 edges from acceptance.
- Grant is combinational in the acceptance cycle; engines must hold req/req_w/req_j/req_last stable until sampled with gnt.
- Switching owners: a lock ends at the edge of the last beat. The other engine can be granted in the very next cycle (no bubble).
- Timeout vs. resumed request in the same cycle: if req[owner]=1 in the cycle idle_cnt==LOCK_TIMEOUT-1, the beat is accepted and no timeout occurs.
- The watchdog counts only in OWNED. A stall in IDLE never times out.
- Reset mid-burst or with responses in flight: responses are discarded, no rsp_valid after RST deasserts, state returns to IDLE with rr=0.

## Test plan
- Single engine, 8-beat burst: engine 0 issues (W,J)=(7,0),(6,1)…(0,7), last on beat 8, table returns Cost=W*8+J → rsp_valid[0] on 8 consecutive cycles, rsp_cost=56,49,…,7, rsp_last on beat 8 only, busy high from beat 1 to beat 8, gnt[1]=0 throughout.
- Contention after reset, both engines request 3-beat bursts simultaneously → engine 0 served first (rr=0); engine 1 granted the cycle after engine 0's last beat; a following simultaneous request is granted to engine 0.
- Single-beat alternation, both engines hold req with req_last=1 every beat → grants alternate 0,1,0,1 with no idle cycle; responses tagged to match.
- Watchdog, LOCK_TIMEOUT=16: engine 0 sends 2 non-last beats, then drops req → exactly 16 stall cycles later busy=0 and err_timeout pulses once; a pending engine 1 is granted the next cycle.
- Near-timeout resume: engine 0 reasserts req in stall cycle 16 → beat accepted, no err_timeout, idle_cnt restarts.
- Async reset mid-burst: assert RST between edges with 2 responses in flight → all outputs go to reset values immediately, no rsp_valid after release, the first request after release is served normally.

Source files
------------

// File: rtl/cost_port_if.sv
// Shared Cost lookup port bundle between the two permutation engines and the arbiter.
interface cost_port_if;
  logic [1:0] req;
  logic [1:0] req_last;
  logic [5:0] req_w;
  logic [5:0] req_j;
  logic [1:0] gnt;
  logic [2:0] W;
  logic [2:0] J;
  logic [6:0] Cost;
  logic [1:0] rsp_valid;
  logic [6:0] rsp_cost;
  logic       rsp_last;
  logic       busy;
  logic       err_timeout;

  // Arbiter side
  modport slave (
    input  req, req_last, req_w, req_j, Cost,
    output gnt, W, J, rsp_valid, rsp_cost, rsp_last, busy, err_timeout
  );

  // Engine / cost-table side
  modport master (
    output req, req_last, req_w, req_j, Cost,
    input  gnt, W, J, rsp_valid, rsp_cost, rsp_last, busy, err_timeout
  );
endinterface

// File: rtl/cost_port_arbiter.sv
// Round-robin, burst-locking arbiter for the shared Cost lookup port.
// state | meaning
// IDLE  | no owner; grant the sole requester, or engine rr on contention
// OWNED | port locked to owner until its last beat or watchdog expiry
module cost_port_arbiter #(
  parameter int unsigned LOCK_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  cost_port_if.slave  bus
);

  localparam logic [7:0] TO_LAST = 8'(LOCK_TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       rr_q, rr_d;
  logic [7:0] idle_cnt_q, idle_cnt_d;
  logic       err_q, err_d;

  logic       winner;
  logic       accept;
  logic       beat_last;
  logic [1:0] gnt;

  logic [2:0] w_q, j_q;
  logic       s1_valid_q, s1_tag_q, s1_last_q;
  logic [1:0] rsp_valid_q;
  logic [6:0] rsp_cost_q;
  logic       rsp_last_q;

  // Grant selection, lock tracking and watchdog next-state logic.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    idle_cnt_d = idle_cnt_q;
    err_d      = 1'b0;
    winner     = rr_q;
    gnt        = 2'b00;

    unique case (state_q)
      IDLE: begin
        case (bus.req)
          2'b01:   winner = 1'b0;
          2'b10:   winner = 1'b1;
          default: winner = rr_q;
        endcase
        if (bus.req != 2'b00) gnt = winner ? 2'b10 : 2'b01;
      end
      OWNED: begin
        // Non-owner is locked out even if it requests.
        winner = owner_q;
        gnt    = owner_q ? {bus.req[1], 1'b0} : {1'b0, bus.req[0]};
      end
      default: ;
    endcase

    accept    = |(bus.req & gnt);
    beat_last = bus.req_last[winner];

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (beat_last) begin
            rr_d = ~winner;
          end else begin
            state_d    = OWNED;
            owner_d    = winner;
            idle_cnt_d = 8'd0;
          end
        end
      end
      OWNED: begin
        if (accept) begin
          if (beat_last) begin
            state_d = IDLE;
            rr_d    = ~owner_q;
          end else begin
            idle_cnt_d = 8'd0;
          end
        end else if (idle_cnt_q == TO_LAST) begin
          // A resumed request in this same cycle wins over the timeout.
          state_d = IDLE;
          rr_d    = ~owner_q;
          err_d   = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      rr_q       <= 1'b0;
      idle_cnt_q <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      idle_cnt_q <= idle_cnt_d;
      err_q      <= err_d;
    end
  end

  // Two-stage lookup pipeline: W/J issue with tag, then Cost capture and routing.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      w_q         <= 3'd0;
      j_q         <= 3'd0;
      s1_valid_q  <= 1'b0;
      s1_tag_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_cost_q  <= 7'd0;
      rsp_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        w_q       <= winner ? bus.req_w[5:3] : bus.req_w[2:0];
        j_q       <= winner ? bus.req_j[5:3] : bus.req_j[2:0];
        s1_tag_q  <= winner;
        s1_last_q <= beat_last;
      end
      if (s1_valid_q) begin
        rsp_valid_q <= s1_tag_q ? 2'b10 : 2'b01;
        rsp_cost_q  <= bus.Cost;
        rsp_last_q  <= s1_last_q;
      end else begin
        rsp_valid_q <= 2'b00;
      end
    end
  end

  assign bus.gnt         = gnt;
  assign bus.W           = w_q;
  assign bus.J           = j_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_cost    = rsp_cost_q;
  assign bus.rsp_last    = rsp_last_q;
  assign bus.busy        = (state_q == OWNED);
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_cost_port_arbiter.sv
// Directed bench for cost_port_arbiter: bursts, contention, alternation, watchdog, async reset.
module tb_cost_port_arbiter;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   errs  = 0;
  int   n_chk = 0;

  cost_port_if bus ();

  cost_port_arbiter #(.LOCK_TIMEOUT(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Cost table: W*8+J
  assign bus.Cost = {1'b0, bus.W, bus.J};

  always #5 CLK = ~CLK;

  // Expected pipeline: e1 = beat accepted last cycle, e2 = response due this cycle.
  logic       e1_v, e1_tag, e1_last, e2_v, e2_tag, e2_last;
  logic [6:0] e1_cost, e2_cost;
  logic [2:0] e_w, e_j;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic clear_model();
    e1_v = 1'b0; e1_tag = 1'b0; e1_last = 1'b0; e1_cost = 7'd0;
    e2_v = 1'b0; e2_tag = 1'b0; e2_last = 1'b0; e2_cost = 7'd0;
    e_w = 3'd0; e_j = 3'd0;
  endtask

  // Entered at posedge+1; asserts RST between edges and releases it mid-cycle.
  task automatic do_reset();
    bus.req = 2'b00; bus.req_last = 2'b00; bus.req_w = 6'd0; bus.req_j = 6'd0;
    #1 RST = 1'b1;
    #1;
    check("rst_W",         32'(bus.W),           32'd0);
    check("rst_J",         32'(bus.J),           32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid),   32'd0);
    check("rst_rsp_cost",  32'(bus.rsp_cost),    32'd0);
    check("rst_rsp_last",  32'(bus.rsp_last),    32'd0);
    check("rst_busy",      32'(bus.busy),        32'd0);
    check("rst_err",       32'(bus.err_timeout), 32'd0);
    check("rst_gnt",       32'(bus.gnt),         32'd0);
    @(posedge CLK);
    #3 RST = 1'b0;
    @(posedge CLK);
    #1;
    clear_model();
  endtask

  // One cycle: drive, check against expectations, advance model, step to next posedge+1.
  task automatic cyc(input logic [1:0] rq, input logic [1:0] lst,
                     input logic [2:0] w0, input logic [2:0] j0,
                     input logic [2:0] w1, input logic [2:0] j1,
                     input logic [1:0] eg, input logic eb, input logic ee);
    logic       tag;
    logic [2:0] ws, js;
    bus.req = rq; bus.req_last = lst; bus.req_w = {w1, w0}; bus.req_j = {j1, j0};
    #1;
    check("gnt",  32'(bus.gnt),         32'(eg));
    check("busy", 32'(bus.busy),        32'(eb));
    check("err",  32'(bus.err_timeout), 32'(ee));
    check("W",    32'(bus.W),           32'(e_w));
    check("J",    32'(bus.J),           32'(e_j));
    check("rsp_valid", 32'(bus.rsp_valid), e2_v ? (e2_tag ? 32'd2 : 32'd1) : 32'd0);
    if (e2_v) begin
      check("rsp_cost", 32'(bus.rsp_cost), 32'(e2_cost));
      check("rsp_last", 32'(bus.rsp_last), 32'(e2_last));
    end
    e2_v = e1_v; e2_tag = e1_tag; e2_last = e1_last; e2_cost = e1_cost;
    e1_v = |(rq & eg);
    if (e1_v) begin
      tag     = eg[1];
      ws      = tag ? w1 : w0;
      js      = tag ? j1 : j0;
      e1_tag  = tag;
      e1_last = lst[tag];
      e1_cost = {1'b0, ws, js};
      e_w     = ws;
      e_j     = js;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bus.req = 2'b00; bus.req_last = 2'b00; bus.req_w = 6'd0; bus.req_j = 6'd0;
    clear_model();
    #1;
    do_reset();

    // 8-beat burst from engine 0; engine 1 waits with a single beat, served right after.
    for (int i = 0; i < 8; i++)
      cyc(2'b11, {1'b1, (i == 7)}, 3'(7 - i), 3'(i), 3'd2, 3'd5, 2'b01, (i != 0), 1'b0);
    cyc(2'b10, 2'b10, 3'd0, 3'd0, 3'd2, 3'd5, 2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);

    // Contention after reset: 3-beat bursts from both, engine 0 first, no bubble.
    do_reset();
    cyc(2'b11, 2'b00, 3'd1, 3'd4, 3'd5, 3'd0, 2'b01, 1'b0, 1'b0);
    cyc(2'b11, 2'b00, 3'd2, 3'd5, 3'd5, 3'd0, 2'b01, 1'b1, 1'b0);
    cyc(2'b11, 2'b01, 3'd3, 3'd6, 3'd5, 3'd0, 2'b01, 1'b1, 1'b0);
    cyc(2'b10, 2'b00, 3'd0, 3'd0, 3'd5, 3'd0, 2'b10, 1'b0, 1'b0);
    cyc(2'b10, 2'b00, 3'd0, 3'd0, 3'd6, 3'd1, 2'b10, 1'b1, 1'b0);
    cyc(2'b10, 2'b10, 3'd0, 3'd0, 3'd7, 3'd2, 2'b10, 1'b1, 1'b0);
    cyc(2'b11, 2'b11, 3'd4, 3'd4, 3'd3, 3'd3, 2'b01, 1'b0, 1'b0);
    cyc(2'b10, 2'b10, 3'd0, 3'd0, 3'd3, 3'd3, 2'b10, 1'b0, 1'b0);

    // Single-beat alternation with both requesting continuously.
    for (int i = 0; i < 4; i++)
      cyc(2'b11, 2'b11, 3'd1, 3'(i), 3'd6, 3'(7 - i), (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 1'b0);

    // Watchdog: two non-last beats, 16-cycle stall, engine 1 granted on release.
    cyc(2'b01, 2'b00, 3'd1, 3'd2, 3'd0, 3'd0, 2'b01, 1'b0, 1'b0);
    cyc(2'b01, 2'b00, 3'd3, 3'd4, 3'd0, 3'd0, 2'b01, 1'b1, 1'b0);
    for (int s = 0; s < 16; s++)
      cyc(2'b10, 2'b10, 3'd0, 3'd0, 3'd6, 3'd6, 2'b00, 1'b1, 1'b0);
    cyc(2'b10, 2'b10, 3'd0, 3'd0, 3'd6, 3'd6, 2'b10, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      cyc(2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);

    // Near-timeout resume in stall cycle 16, counter restarts, then normal finish.
    cyc(2'b01, 2'b00, 3'd5, 3'd5, 3'd0, 3'd0, 2'b01, 1'b0, 1'b0);
    for (int s = 0; s < 15; s++)
      cyc(2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b1, 1'b0);
    cyc(2'b01, 2'b00, 3'd2, 3'd3, 3'd0, 3'd0, 2'b01, 1'b1, 1'b0);
    for (int s = 0; s < 15; s++)
      cyc(2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b1, 1'b0);
    cyc(2'b01, 2'b01, 3'd4, 3'd1, 3'd0, 3'd0, 2'b01, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);

    // Async reset mid-burst with responses in flight; rr must return to 0.
    cyc(2'b01, 2'b00, 3'd6, 3'd2, 3'd0, 3'd0, 2'b01, 1'b0, 1'b0);
    cyc(2'b01, 2'b00, 3'd5, 3'd3, 3'd0, 3'd0, 2'b01, 1'b1, 1'b0);
    cyc(2'b01, 2'b00, 3'd4, 3'd4, 3'd0, 3'd0, 2'b01, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 2; i++)
      cyc(2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);
    cyc(2'b11, 2'b11, 3'd7, 3'd7, 3'd1, 3'd1, 2'b01, 1'b0, 1'b0);
    cyc(2'b10, 2'b10, 3'd0, 3'd0, 3'd1, 3'd1, 2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end

endmodule
